// File: rtl/twin_word_serializer.sv
// twin_word_serializer
//   Takes one (d1, d2) word pair per valid/ready handshake and sends it on a
//   single serial line, LSB first: all of d1, then all of d2, then an optional
//   even-parity bit over the 2*WIDTH data bits.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   clr         synchronous abort, active high; drops the current frame
//   in_valid    producer offers a pair on d1/d2
//   in_ready    pair can be accepted (IDLE only)
//   d1, d2      first and second word of the pair
//   ser_out     serial data bit
//   ser_valid   ser_out carries a frame bit
//   frame_start cycle carrying d1[0]
//   frame_end   cycle carrying the last frame bit
//   busy        frame in progress
//   done        one-cycle pulse in the first IDLE cycle after a normal frame
module twin_word_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StSend1,
        StSend2,
        StParity
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sh1_q;
    logic [WIDTH-1:0] sh2_q;
    logic [CW-1:0]    cnt_q;
    logic             par_q;
    logic             done_q;
    logic             last_bit;

    // Terminal count is evaluated in the cycle the bit is on the line.
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            sh1_q   <= '0;
            sh2_q   <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clr) begin
                // Abort wins over accept and never produces a done pulse.
                state_q <= StIdle;
                sh1_q   <= '0;
                sh2_q   <= '0;
                cnt_q   <= '0;
                par_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (in_valid) begin
                            sh1_q   <= d1;
                            sh2_q   <= d2;
                            cnt_q   <= '0;
                            par_q   <= 1'b0;
                            state_q <= StSend1;
                        end
                    end
                    StSend1: begin
                        sh1_q <= sh1_q >> 1;
                        par_q <= par_q ^ sh1_q[0];
                        if (last_bit) begin
                            cnt_q   <= '0;
                            state_q <= StSend2;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    StSend2: begin
                        sh2_q <= sh2_q >> 1;
                        par_q <= par_q ^ sh2_q[0];
                        if (last_bit) begin
                            cnt_q <= '0;
                            if (PARITY_EN) begin
                                state_q <= StParity;
                            end else begin
                                state_q <= StIdle;
                                par_q   <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    StParity: begin
                        state_q <= StIdle;
                        par_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // All outputs decode registered state only; no input-to-output path.
    always_comb begin
        ser_out     = 1'b0;
        ser_valid   = (state_q != StIdle);
        busy        = (state_q != StIdle);
        in_ready    = (state_q == StIdle);
        frame_start = (state_q == StSend1) && (cnt_q == '0);
        frame_end   = PARITY_EN ? (state_q == StParity)
                                : ((state_q == StSend2) && last_bit);
        done        = done_q;
        case (state_q)
            StSend1:  ser_out = sh1_q[0];
            StSend2:  ser_out = sh2_q[0];
            StParity: ser_out = par_q;
            default:  ser_out = 1'b0;
        endcase
    end

endmodule

// File: doc/twin_word_serializer.md
Name: twin_word_serializer

Overview:
Downstream stage of the twin 8-bit register pair. Accepts one (d1, d2) word pair per valid/ready handshake and shifts it out on a single serial line, LSB first: d1 first, then d2, then an optional even-parity bit. Frame markers and a completion pulse let the next stage (line driver or checker) frame the stream.

Parameters:
WIDTH, 8, bit width of each input word d1/d2.
PARITY_EN, 1, 1 = append one even-parity bit after d2; 0 = frame ends after the last d2 bit.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  asynchronous reset, active-low (0 = reset).
clr  input  1  synchronous abort, active-high.
in_valid  input  1  producer has a word pair on d1/d2.
in_ready  output  1  block can accept a pair (high only in IDLE).
d1  input  WIDTH  first word, sent first.
d2  input  WIDTH  second word, sent after d1.
ser_out  output  1  serial data bit.
ser_valid  output  1  ser_out carries a frame bit this cycle.
frame_start  output  1  high in the cycle carrying d1[0].
frame_end  output  1  high in the cycle carrying the last frame bit.
busy  output  1  frame in progress (state != IDLE).
done  output  1  one-cycle pulse after a frame completes normally.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; shift registers, bit counter and parity accumulator = 0.
  - ser_out, ser_valid, frame_start, frame_end, busy, done = 0.
  - in_ready = 1, because state is IDLE, but nothing is captured while rst=0.
- States: IDLE, SEND1, SEND2, PARITY. PARITY is skipped when PARITY_EN=0.
- Accept:
  - A pair is accepted on the rising edge where in_valid=1, in_ready=1 and clr=0.
  - d1 and d2 are latched and the counter is set to 0; next state is SEND1.
  - in_valid while busy is ignored and the pair is not captured.
- Latency: d1[0] appears on ser_out with ser_valid=1 and frame_start=1 in the cycle immediately after the accept edge.
- SEND1: ser_out=d1 shift reg[0]. Shift right each cycle, counter+1. After WIDTH cycles go to SEND2 and reset the counter.
- SEND2: same for d2. After WIDTH cycles go to PARITY, or to IDLE if PARITY_EN=0.
- PARITY: ser_out = XOR of all 2*WIDTH data bits (even parity over the frame). One cycle, then go to IDLE.
- Frame length is 2*WIDTH+PARITY_EN cycles, with ser_valid continuously high.
- frame_end is high in the last frame bit cycle only.
- done is registered: a single-cycle pulse in the first IDLE cycle after a normal frame end.
- in_ready=1 in that same cycle, so a new pair may be accepted on the edge ending it. The minimum inter-frame gap is therefore 1 cycle.
- Outputs are decoded from registered state and shift registers; there is no combinational path from inputs to outputs except none (in_ready depends on state only).
- clr=1 at an edge:
  - Forces IDLE and clears the shift registers, counter and parity; done is not pulsed.
  - clr has priority over accept. A clr in IDLE is a no-op.
- Reset asserted mid-frame: immediate return to the reset values. The partial frame is dropped and no done pulse is produced.
- Counter width is clog2(WIDTH)+1. Terminal count is WIDTH-1, checked in the cycle the bit is driven.

Test Plan:
- rst=0 for 2 cycles, then release -> all outputs 0, in_ready=1. in_valid pulsed during reset is not captured (busy stays 0).
- Accept d1=8'hAA, d2=8'hF0 -> ser_out over 17 cycles = 0,1,0,1,0,1,0,1, 0,0,0,0,1,1,1,1, then parity 0.
  - frame_start in cycle 1, frame_end in cycle 17, done pulse in cycle 18.
- Accept d1=8'hCC, d2=8'hE3 -> bits 0,0,1,1,0,0,1,1, 1,1,0,0,0,1,1,1, then parity 1 (popcount 9).
- Back-to-back: hold in_valid=1 with pair 2 (d1=8'h01, d2=8'h80) queued behind pair 1 -> pair 2 is accepted on the edge ending the done cycle.
  - Its frame_start follows one idle cycle; in_valid held during pair 1's frame is not captured early.
- clr=1 during SEND2 bit 3 -> next cycle state IDLE, ser_valid=0, no done. A new pair (8'h0F, 8'h00) then serializes correctly, with parity 0.
- PARITY_EN=0 instance with d1=8'hFF, d2=8'h00 -> 16-bit frame, frame_end on the last d2 bit, done in cycle 17.
  - Assert rst mid-SEND1 -> outputs drop to 0 asynchronously, without waiting for a clock edge.
